// File: rtl/opto_pio_pkg.sv
// Shared register map and bus widths for the opto PIO block.
// The register offsets are used by the top-level write decode and read mux.
package opto_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMSK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_RISEEN = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_FALLEN = 3'd7;

endpackage

// File: rtl/opto_debounce.sv
// Single-bit debounce filter: filt_o only moves after the synchronised input
// has disagreed with it for DEBOUNCE consecutive cycles.
module opto_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_i,
    output logic filt_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_i != filt_q) begin
            // The cycle the count hits LAST is the DEBOUNCE-th disagreeing cycle.
            if (cnt_q == LAST) begin
                filt_d = sync_i;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/opto_pio_gen2.sv
// Avalon-MM bidirectional opto I/O port: per-bit direction, atomic set/clear,
// synchronised + debounced inputs, edge capture and a maskable level irq.
module opto_pio_gen2
    import opto_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  readdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  bidir_port
);

    logic                              wr;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  filt;
    logic [WIDTH-1:0]                  filt_dly_q;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqmsk_q, irqmsk_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] riseen_q, riseen_d;
    logic [WIDTH-1:0] fallen_q, fallen_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    assign wr = chipselect & ~write_n;

    // Output-mode bits keep sampling their own pin, so no gating on DIR here.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            assign bidir_port[g] = dir_q[g] ? data_out_q[g] : 1'bz;

            opto_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .sync_i  (sync_q[SYNC_STAGES-1][g]),
                .filt_o  (filt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bidir_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmsk_d   = irqmsk_q;
        riseen_d   = riseen_q;
        fallen_d   = fallen_q;
        edge_clr   = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_out_d = writedata;
                ADDR_DIR:    dir_d      = writedata;
                ADDR_IRQMSK: irqmsk_d   = writedata;
                ADDR_EDGE:   edge_clr   = writedata;
                ADDR_OUTSET: data_out_d = data_out_q | writedata;
                ADDR_OUTCLR: data_out_d = data_out_q & ~writedata;
                ADDR_RISEEN: riseen_d   = writedata;
                ADDR_FALLEN: fallen_d   = writedata;
                default:     ;
            endcase
        end
    end

    // A fresh edge in the same cycle as its W1C clear survives.
    always_comb begin
        rise   = filt & ~filt_dly_q & riseen_q;
        fall   = ~filt & filt_dly_q & fallen_q;
        edge_d = (edge_q & ~edge_clr) | rise | fall;
        irq_d  = |(edge_q & irqmsk_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d = filt;
            ADDR_DIR:    readdata_d = dir_q;
            ADDR_IRQMSK: readdata_d = irqmsk_q;
            ADDR_EDGE:   readdata_d = edge_q;
            ADDR_RISEEN: readdata_d = riseen_q;
            ADDR_FALLEN: readdata_d = fallen_q;
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irqmsk_q   <= '0;
            edge_q     <= '0;
            riseen_q   <= '0;
            fallen_q   <= '0;
            filt_dly_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irqmsk_q   <= irqmsk_d;
            edge_q     <= edge_d;
            riseen_q   <= riseen_d;
            fallen_q   <= fallen_d;
            filt_dly_q <= filt;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_opto_pio_gen2.sv
// Bench for opto_pio_gen2: expected values queued as stimulus is applied,
// popped and compared once the DUT output is due.
module tb_opto_pio_gen2;
    import opto_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        chipselect1 = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata, readdata1;
    logic        irq, irq1;
    wire  [15:0] pins0;
    wire  [15:0] pins1;

    logic [15:0] tb_oe  = '0;
    logic [15:0] tb_val = '0;
    logic [15:0] tb_val1 = 16'h0001;

    logic [15:0] exp_q[$];
    logic [15:0] got, exp;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign pins0[i] = tb_oe[i] ? tb_val[i] : 1'bz;
        assign pins1[i] = tb_val1[i];
    end

    opto_pio_gen2 #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .bidir_port(pins0)
    );

    opto_pio_gen2 #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect1),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1), .irq(irq1),
        .bidir_port(pins1)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset;
        tick(3);
        exp_q.push_back(16'h0000);
        exp_q.push_back({15'd0, 1'b0});
        exp = exp_q.pop_front(); total++;
        if (readdata !== exp) begin bad++; $display("FAIL reset_readdata got=%h exp=%h", readdata, exp); end
        exp = exp_q.pop_front(); total++;
        if ({15'd0, irq} !== exp) begin bad++; $display("FAIL reset_irq got=%b exp=%h", irq, exp); end
        reset_n = 1'b1;
        tick();
        wr(ADDR_DIR, 16'h00FF);
        wr(ADDR_DATA, 16'hA5A5);
        exp_q.push_back(16'h00A5);
        exp = exp_q.pop_front(); total++;
        if ({8'h00, pins0[7:0]} !== exp) begin bad++; $display("FAIL pins_low got=%h exp=%h", pins0[7:0], exp); end
        total++;
        if (pins0[15:8] !== 8'h00 && pins0[15:8] !== 8'hzz) begin
            bad++; $display("FAIL pins_high_z got=%h exp=zz", pins0[15:8]);
        end
        exp_q.push_back(16'h00FF);
        rd(ADDR_DIR, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL read_dir got=%h exp=%h", got, exp); end
    endtask

    task automatic test_set_clr;
        wr(ADDR_DIR, 16'hFFFF);
        wr(ADDR_DATA, 16'h00F0);
        wr(ADDR_OUTSET, 16'h0003);
        wr(ADDR_OUTCLR, 16'h0010);
        exp_q.push_back(16'h00E3);
        exp = exp_q.pop_front(); total++;
        if (pins0 !== exp) begin bad++; $display("FAIL setclr_pins got=%h exp=%h", pins0, exp); end
        tick(10);
        exp_q.push_back(16'h00E3);
        rd(ADDR_DATA, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL setclr_data got=%h exp=%h", got, exp); end
        exp_q.push_back(16'h0000);
        rd(ADDR_OUTSET, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL outset_read got=%h exp=%h", got, exp); end
        exp_q.push_back(16'h0000);
        rd(ADDR_OUTCLR, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL outclr_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_debounce;
        wr(ADDR_DIR, 16'h0000);
        tb_val = '0; tb_oe = 16'hFFFF;
        tick(15);
        wr(ADDR_RISEEN, 16'h0001);
        wr(ADDR_FALLEN, 16'h0001);
        wr(ADDR_EDGE, 16'hFFFF);
        tb_val[0] = 1'b1;
        tick(3);
        tb_val[0] = 1'b0;
        tick(10);
        exp_q.push_back(16'h0000);
        rd(ADDR_DATA, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL glitch_filt got=%h exp=%h", got, exp); end
        exp_q.push_back(16'h0000);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL glitch_edge got=%h exp=%h", got, exp); end
        // readdata lags filt by one cycle, so filt rising at +6 shows at +7.
        address = ADDR_DATA;
        tb_val[0] = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) tb_val[0] = 1'b0;
            if (k == 6 || k == 7) begin
                exp = exp_q.pop_front(); total++;
                if (readdata !== exp) begin bad++; $display("FAIL pulse_latency k=%0d got=%h exp=%h", k, readdata, exp); end
            end
        end
        tick(12);
        exp_q.push_back(16'h0001);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL pulse_edge got=%h exp=%h", got, exp); end
        wr(ADDR_EDGE, 16'hFFFF);
    endtask

    task automatic test_edge_irq;
        wr(ADDR_FALLEN, 16'h0000);
        wr(ADDR_RISEEN, 16'h0001);
        wr(ADDR_EDGE, 16'hFFFF);
        wr(ADDR_IRQMSK, 16'h0001);
        tb_val[0] = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7 || k == 8) begin
                exp = exp_q.pop_front(); total++;
                if ({15'd0, irq} !== exp) begin bad++; $display("FAIL irq_latency k=%0d got=%b exp=%h", k, irq, exp); end
            end
        end
        exp_q.push_back(16'h0001);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL rise_edge got=%h exp=%h", got, exp); end
        wr(ADDR_EDGE, 16'h0001);
        tick();
        exp_q.push_back(16'h0000);
        exp = exp_q.pop_front(); total++;
        if ({15'd0, irq} !== exp) begin bad++; $display("FAIL irq_cleared got=%b exp=%h", irq, exp); end
        exp_q.push_back(16'h0000);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL w1c_edge got=%h exp=%h", got, exp); end
        tb_val[0] = 1'b0;
        tick(12);
        exp_q.push_back(16'h0000);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL fall_disabled got=%h exp=%h", got, exp); end
    endtask

    task automatic test_set_wins;
        wr(ADDR_RISEEN, 16'h0003);
        tb_val[1] = 1'b1;
        tick(10);
        exp_q.push_back(16'h0002);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL bit1_edge got=%h exp=%h", got, exp); end
        // The W1C write lands on the same edge that captures the bit0 rise.
        tb_val[0] = 1'b1;
        tick(6);
        exp_q.push_back(16'h0001);
        wr(ADDR_EDGE, 16'h0003);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL set_wins got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid;
        tb_val = '0;
        tick(15);
        tb_val = 16'h0005;
        tick(4);
        reset_n = 1'b0;
        #1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp = exp_q.pop_front(); total++;
        if (readdata !== exp) begin bad++; $display("FAIL midrst_readdata got=%h exp=%h", readdata, exp); end
        exp = exp_q.pop_front(); total++;
        if ({15'd0, irq} !== exp) begin bad++; $display("FAIL midrst_irq got=%b exp=%h", irq, exp); end
        tick(2);
        address = ADDR_DATA;
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3) begin
                exp_q.push_back(16'h0000);
                exp = exp_q.pop_front(); total++;
                if (readdata1 !== exp) begin bad++; $display("FAIL deb1_early got=%h exp=%h", readdata1, exp); end
            end
            if (k == 4) begin
                exp_q.push_back(16'h0001);
                exp = exp_q.pop_front(); total++;
                if (readdata1 !== exp) begin bad++; $display("FAIL deb1_latency got=%h exp=%h", readdata1, exp); end
            end
            if (k == 6) begin
                exp_q.push_back(16'h0000);
                exp = exp_q.pop_front(); total++;
                if (readdata !== exp) begin bad++; $display("FAIL rst_early got=%h exp=%h", readdata, exp); end
            end
            if (k == 7) begin
                exp_q.push_back(16'h0005);
                exp = exp_q.pop_front(); total++;
                if (readdata !== exp) begin bad++; $display("FAIL rst_latency got=%h exp=%h", readdata, exp); end
            end
        end
        exp_q.push_back(16'h0000);
        rd(ADDR_EDGE, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL rst_no_edge got=%h exp=%h", got, exp); end
        exp_q.push_back(16'h0000);
        rd(ADDR_DIR, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL rst_dir got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_set_clr();
        test_debounce();
        test_edge_irq();
        test_set_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
